// File: rtl/prbs_gen_check.sv
// prbs_gen_check: multi-lane PRBS generator and self-synchronising
// checker with lock hysteresis and saturating per-lane error counters.
module prbs_gen_check #(
    parameter int           N_CHANNELS = 1,
    parameter int           W          = 32,
    parameter logic [W-1:0] POLY       = W'(32'h80000057),
    parameter int           ITERATIONS = 1,
    parameter int           LOCK_COUNT = 4,
    parameter int           UNLOCK_ERR = 4,
    parameter int           CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        aresetn,
    output logic [W*N_CHANNELS-1:0]     m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic                        inject_err,
    input  logic [W*N_CHANNELS-1:0]     s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        err_clear,
    output logic [N_CHANNELS-1:0]       lock,
    output logic [CNT_W*N_CHANNELS-1:0] word_err_cnt,
    output logic [CNT_W*N_CHANNELS-1:0] bit_err_cnt
);

    localparam int PW = $clog2(W + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_ERR + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } chk_state_t;

    function automatic logic [W-1:0] advance(input logic [W-1:0] s);
        logic [W-1:0] t;
        t = s;
        for (int i = 0; i < ITERATIONS; i++)
            t = {t[W-2:0], ^(t & POLY)};
        return t;
    endfunction

    logic [W-1:0] gen_state;
    logic         inj_flag;
    logic         gen_beat;

    assign gen_beat      = m_axis_tvalid & m_axis_tready;
    assign s_axis_tready = 1'b1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            gen_state     <= '1;
            m_axis_tvalid <= 1'b0;
            inj_flag      <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b1;
            if (gen_beat) begin
                gen_state <= advance(gen_state);
                inj_flag  <= inject_err;
            end else if (inject_err) begin
                inj_flag <= 1'b1;
            end
        end
    end

    // Every lane starts from the same seed, so one LFSR serves all lanes.
    assign m_axis_tdata = {N_CHANNELS{gen_state ^ W'(inj_flag)}};

    for (genvar j = 0; j < N_CHANNELS; j++) begin : g_lane
        chk_state_t       st, st_n;
        logic [W-1:0]     seed, seed_n;
        logic [W-1:0]     rx, expd, diff;
        logic [GW-1:0]    good, good_n;
        logic [BW-1:0]    bad, bad_n;
        logic             lk, lk_n;
        logic [CNT_W-1:0] wcnt, wcnt_n;
        logic [CNT_W-1:0] bcnt, bcnt_n;
        logic [PW-1:0]    pop;
        logic [SW-1:0]    bsum;
        logic             mism;

        assign rx   = s_axis_tdata[W*j +: W];
        assign expd = advance(seed);
        assign diff = rx ^ expd;
        assign mism = |diff;
        assign pop  = PW'($countones(diff));
        assign bsum = SW'(bcnt) + SW'(pop);

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                st   <= SEED;
                seed <= '0;
                good <= '0;
                bad  <= '0;
                lk   <= 1'b0;
                wcnt <= '0;
                bcnt <= '0;
            end else begin
                st   <= st_n;
                seed <= seed_n;
                good <= good_n;
                bad  <= bad_n;
                lk   <= lk_n;
                wcnt <= wcnt_n;
                bcnt <= bcnt_n;
            end
        end

        always_comb begin
            st_n   = st;
            seed_n = seed;
            good_n = good;
            bad_n  = bad;
            lk_n   = lk;
            wcnt_n = wcnt;
            bcnt_n = bcnt;
            if (s_axis_tvalid) begin
                seed_n = rx;
                unique case (st)
                    SEED: begin
                        st_n   = HUNT;
                        good_n = '0;
                    end
                    HUNT: begin
                        if (mism) begin
                            good_n = '0;
                        end else if (good == GW'(LOCK_COUNT - 1)) begin
                            st_n   = LOCKED;
                            lk_n   = 1'b1;
                            good_n = '0;
                            bad_n  = '0;
                        end else begin
                            good_n = good + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!mism) begin
                            bad_n = '0;
                        end else begin
                            if (wcnt != CNT_MAX)
                                wcnt_n = wcnt + CNT_W'(1);
                            // Clamp rather than wrap on overflow.
                            if (bsum > SW'(CNT_MAX))
                                bcnt_n = CNT_MAX;
                            else
                                bcnt_n = bsum[CNT_W-1:0];
                            if (bad == BW'(UNLOCK_ERR - 1)) begin
                                st_n   = HUNT;
                                lk_n   = 1'b0;
                                good_n = '0;
                                bad_n  = '0;
                            end else begin
                                bad_n = bad + BW'(1);
                            end
                        end
                    end
                    default: st_n = SEED;
                endcase
            end
            if (err_clear) begin
                wcnt_n = '0;
                bcnt_n = '0;
            end
        end

        assign lock[j]                      = lk;
        assign word_err_cnt[CNT_W*j +: CNT_W] = wcnt;
        assign bit_err_cnt[CNT_W*j +: CNT_W]  = bcnt;
    end

endmodule

// File: tb/tb_prbs_gen_check.sv
// tb_prbs_gen_check: directed loopback and corruption scenarios checked
// against a behavioural generator/checker model through a scoreboard.
module tb_prbs_gen_check;

    localparam int N    = 2;
    localparam int W    = 32;
    localparam int LC   = 4;
    localparam int UE   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] TAPS = 32'h80000057;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [63:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          inject_err;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          err_clear;
    logic [1:0]    lock;
    logic [7:0]    word_err_cnt;
    logic [7:0]    bit_err_cnt;
    logic [31:0]   cor0;

    always #5 clk = ~clk;

    // Loopback; lane 0 can be corrupted on its way back in.
    assign s_axis_tdata  = m_axis_tdata ^ {32'h0, cor0};
    assign s_axis_tvalid = m_axis_tvalid & m_axis_tready;

    prbs_gen_check #(
        .N_CHANNELS (N),
        .W          (W),
        .POLY       (TAPS),
        .ITERATIONS (1),
        .LOCK_COUNT (LC),
        .UNLOCK_ERR (UE),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .inject_err    (inject_err),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .err_clear     (err_clear),
        .lock          (lock),
        .word_err_cnt  (word_err_cnt),
        .bit_err_cnt   (bit_err_cnt)
    );

    typedef struct packed {
        logic [1:0] lk;
        logic [7:0] w;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int nbad  = 0;

    logic [31:0] gst;
    bit          gvalid;
    bit          ginj;
    int          mst[N];
    logic [31:0] mseed[N];
    int          mgood[N];
    int          mbad[N];
    int          mw[N];
    int          mb[N];
    bit          mlock[N];

    function automatic logic [31:0] mstep(input logic [31:0] s);
        return (s << 1) | {31'b0, ^(s & TAPS)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        gst    = '1;
        gvalid = 0;
        ginj   = 0;
        for (int l = 0; l < N; l++) begin
            mst[l]   = 0;
            mseed[l] = '0;
            mgood[l] = 0;
            mbad[l]  = 0;
            mw[l]    = 0;
            mb[l]    = 0;
            mlock[l] = 0;
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next one.
    task automatic tick();
        logic [31:0] gw, d, e;
        int          pc;
        bit          beat;
        exp_t        x, y;
        gw = gst ^ {31'b0, ginj};
        check("tvalid", 64'(m_axis_tvalid), 64'(gvalid));
        if (gvalid) begin
            check("tdata0", 64'(m_axis_tdata[31:0]), 64'(gw));
            check("tdata1", 64'(m_axis_tdata[63:32]), 64'(gw));
        end
        beat = gvalid && m_axis_tready;
        if (beat) begin
            for (int l = 0; l < N; l++) begin
                d  = (l == 0) ? (gw ^ cor0) : gw;
                e  = mstep(mseed[l]);
                pc = $countones(d ^ e);
                if (mst[l] == 0) begin
                    mst[l] = 1;
                end else if (mst[l] == 1) begin
                    if (pc == 0) mgood[l]++;
                    else mgood[l] = 0;
                    if (mgood[l] == LC) begin
                        mst[l]   = 2;
                        mlock[l] = 1;
                        mbad[l]  = 0;
                    end
                end else begin
                    if (pc == 0) begin
                        mbad[l] = 0;
                    end else begin
                        mw[l] = (mw[l] >= CMAX) ? CMAX : mw[l] + 1;
                        mb[l] = (mb[l] + pc > CMAX) ? CMAX : mb[l] + pc;
                        mbad[l]++;
                    end
                    if (mbad[l] == UE) begin
                        mst[l]   = 1;
                        mlock[l] = 0;
                        mgood[l] = 0;
                        mbad[l]  = 0;
                    end
                end
                mseed[l] = d;
            end
        end
        if (err_clear) begin
            for (int l = 0; l < N; l++) begin
                mw[l] = 0;
                mb[l] = 0;
            end
        end
        if (beat) begin
            gst  = mstep(gst);
            ginj = inject_err;
        end else begin
            ginj = ginj | inject_err;
        end
        gvalid = 1;
        x.lk = {mlock[1], mlock[0]};
        x.w  = {4'(mw[1]), 4'(mw[0])};
        x.b  = {4'(mb[1]), 4'(mb[0])};
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check("lock", 64'(lock), 64'(y.lk));
        check("word_cnt", 64'(word_err_cnt), 64'(y.w));
        check("bit_cnt", 64'(bit_err_cnt), 64'(y.b));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] c, pc0;
        aresetn       = 0;
        m_axis_tready = 1;
        inject_err    = 0;
        err_clear     = 0;
        cor0          = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_lock", 64'(lock), 64'(0));
        check("rst_wcnt", 64'(word_err_cnt), 64'(0));
        check("rst_bcnt", 64'(bit_err_cnt), 64'(0));

        aresetn = 1;
        tick();
        check("tvalid_rise", 64'(m_axis_tvalid), 64'(1));
        check("beat0", 64'(m_axis_tdata[31:0]), 64'(32'hFFFFFFFF));
        tick();
        check("beat1", 64'(m_axis_tdata[31:0]), 64'(32'hFFFFFFFE));
        tick();
        check("beat2", 64'(m_axis_tdata[31:0]), 64'(32'hFFFFFFFD));
        tick();
        tick();
        check("prelock4", 64'(lock), 64'(2'b00));
        tick();
        check("lock5", 64'(lock), 64'(2'b11));

        repeat (10000) tick();
        check("soak_lock", 64'(lock), 64'(2'b11));
        check("soak_wcnt", 64'(word_err_cnt), 64'(0));
        check("soak_bcnt", 64'(bit_err_cnt), 64'(0));

        // Bit 0 flip: 1 bit in the bad word, 2 in the word predicted from it.
        inject_err = 1;
        tick();
        inject_err = 0;
        repeat (6) tick();
        check("inj_lock", 64'(lock), 64'(2'b11));
        check("inj_wcnt", 64'(word_err_cnt), 64'(8'h22));
        check("inj_bcnt", 64'(bit_err_cnt), 64'(8'h33));

        err_clear = 1;
        tick();
        err_clear = 0;
        check("clr_wcnt", 64'(word_err_cnt), 64'(0));
        check("clr_bcnt", 64'(bit_err_cnt), 64'(0));

        pc0 = '0;
        for (int i = 0; i < UE; i++) begin
            c = $urandom;
            if (c == mstep(pc0)) c = c ^ 32'h1;
            cor0 = c;
            pc0  = c;
            tick();
            if (i == UE - 2)
                check("rnd_prefall", 64'(lock), 64'(2'b11));
        end
        check("rnd_fall", 64'(lock), 64'(2'b10));
        check("rnd_wcnt", 64'(word_err_cnt), 64'(8'h04));
        cor0 = '0;
        repeat (6) tick();
        check("relock", 64'(lock), 64'(2'b11));
        check("hunt_nocnt", 64'(word_err_cnt), 64'(8'h04));

        err_clear = 1;
        tick();
        err_clear     = 0;
        m_axis_tready = 0;
        repeat (7) tick();
        m_axis_tready = 1;
        repeat (10) tick();
        check("stall_lock", 64'(lock), 64'(2'b11));
        check("stall_wcnt", 64'(word_err_cnt), 64'(0));
        check("stall_bcnt", 64'(bit_err_cnt), 64'(0));

        for (int i = 0; i < 30; i++) begin
            cor0 = (i % 3 == 0) ? 32'h1 : 32'h0;
            tick();
        end
        cor0 = '0;
        check("sat_lock", 64'(lock), 64'(2'b11));
        check("sat_wcnt", 64'(word_err_cnt), 64'(8'h0F));
        check("sat_bcnt", 64'(bit_err_cnt), 64'(8'h0F));

        cor0      = 32'h1;
        err_clear = 1;
        tick();
        cor0      = '0;
        err_clear = 0;
        check("coinc_wcnt", 64'(word_err_cnt), 64'(0));
        tick();
        check("after_wcnt", 64'(word_err_cnt), 64'(8'h01));

        aresetn = 0;
        #1;
        check("mid_lock", 64'(lock), 64'(0));
        check("mid_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("mid_wcnt", 64'(word_err_cnt), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        aresetn = 1;
        tick();
        repeat (4) tick();
        check("re_prelock", 64'(lock), 64'(2'b00));
        tick();
        check("re_lock", 64'(lock), 64'(2'b11));

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
